// File: rtl/camera_pixel_unpacker.sv
// Unpacks multi-tap camera words into a single-pixel stream with x/y coordinates,
// tracking frame/line boundaries from the FVAL/LVAL sideband of accepted words.
module camera_pixel_unpacker #(
    parameter int unsigned TAPS        = 3,
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned H_RES       = 512,
    parameter int unsigned V_RES       = 512,
    parameter int unsigned COORD_WIDTH = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_word_valid,
    output logic                     o_word_ready,
    input  logic [TAPS*PIX_W-1:0]    i_word_data,
    input  logic                     i_fval,
    input  logic                     i_lval,
    input  logic                     i_dval,
    input  logic                     i_tap_reverse,
    output logic                     o_pixel_valid,
    input  logic                     i_pixel_ready,
    output logic [PIX_W-1:0]         o_pixel_data,
    output logic [COORD_WIDTH-1:0]   o_pixel_x,
    output logic [COORD_WIDTH-1:0]   o_pixel_y,
    output logic                     o_frame_done,
    output logic                     o_line_err,
    output logic [15:0]              o_frame_cnt,
    output logic                     o_sync_fval,
    output logic                     o_sync_lval
);

    localparam int unsigned WORD_W = TAPS * PIX_W;
    localparam int unsigned TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0]       LAST_TAP  = TAP_W'(TAPS - 1);
    localparam logic [COORD_WIDTH-1:0] COORD_MAX = '1;
    localparam logic [COORD_WIDTH-1:0] H_LIM     = COORD_WIDTH'(H_RES);
    localparam logic [COORD_WIDTH-1:0] V_LIM     = COORD_WIDTH'(V_RES);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [WORD_W-1:0]        word_q, word_d;
    logic                     rev_q, rev_d;
    logic [TAP_W-1:0]         idx_q, idx_d;
    logic [COORD_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic                     sync_fval_q, sync_fval_d;
    logic                     sync_lval_q, sync_lval_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;
    logic                     pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0]         pix_data_q, pix_data_d;
    logic [COORD_WIDTH-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic                     frame_done_q, frame_done_d;
    logic                     line_err_q, line_err_d;

    logic                     word_accept;
    logic                     tap_advance;
    logic                     fval_rise, fval_fall, line_end;
    logic [COORD_WIDTH-1:0]   x_base, y_base, x_adv;

    function automatic logic [PIX_W-1:0] get_tap(input logic [WORD_W-1:0] word,
                                                 input logic [TAP_W-1:0]  k,
                                                 input logic              rev);
        logic [TAP_W-1:0] sel;
        sel = rev ? (LAST_TAP - k) : k;
        return PIX_W'(word >> (sel * PIX_W));
    endfunction

    function automatic logic [COORD_WIDTH-1:0] sat_inc(input logic [COORD_WIDTH-1:0] c);
        return (c == COORD_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic in_range(input logic [COORD_WIDTH-1:0] x,
                                      input logic [COORD_WIDTH-1:0] y);
        return (x < H_LIM) && (y < V_LIM);
    endfunction

    // Words are only taken while idle; reset forces ready low.
    assign o_word_ready = (state_q == IDLE) && !i_rst;
    assign word_accept  = i_word_valid && o_word_ready;
    // A dropped tap (valid low) still costs one cycle and then moves on.
    assign tap_advance  = !pix_valid_q || i_pixel_ready;

    assign fval_rise = i_fval && !sync_fval_q;
    assign fval_fall = !i_fval && sync_fval_q;
    // A line end also counts when FVAL drops in the same word.
    assign line_end  = !i_lval && sync_lval_q && (i_fval || sync_fval_q);

    // Next-state and register updates.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        rev_d        = rev_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        sync_fval_d  = sync_fval_q;
        sync_lval_d  = sync_lval_q;
        frame_cnt_d  = frame_cnt_q;
        pix_valid_d  = pix_valid_q;
        pix_data_d   = pix_data_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_done_d = 1'b0;
        line_err_d   = 1'b0;
        x_base       = x_q;
        y_base       = y_q;
        x_adv        = sat_inc(x_q);

        case (state_q)
            IDLE: begin
                if (word_accept) begin
                    word_d      = i_word_data;
                    rev_d       = i_tap_reverse;
                    sync_fval_d = i_fval;
                    sync_lval_d = i_lval;
                    if (fval_rise) begin
                        x_base = '0;
                        y_base = '0;
                    end
                    if (fval_fall) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end
                    if (line_end) begin
                        line_err_d = (x_base != H_LIM);
                        x_base     = '0;
                        y_base     = sat_inc(y_base);
                    end
                    x_d = x_base;
                    y_d = y_base;
                    // Tap 0 is presented straight from the incoming word.
                    if (i_lval && i_dval) begin
                        state_d     = EMIT;
                        idx_d       = '0;
                        pix_data_d  = get_tap(i_word_data, '0, i_tap_reverse);
                        pix_x_d     = x_base;
                        pix_y_d     = y_base;
                        pix_valid_d = in_range(x_base, y_base);
                    end
                end
            end
            EMIT: begin
                if (tap_advance) begin
                    x_d = x_adv;
                    if (idx_q == LAST_TAP) begin
                        state_d     = IDLE;
                        pix_valid_d = 1'b0;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        pix_data_d  = get_tap(word_q, idx_q + 1'b1, rev_q);
                        pix_x_d     = x_adv;
                        pix_y_d     = y_q;
                        pix_valid_d = in_range(x_adv, y_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            word_q       <= '0;
            rev_q        <= 1'b0;
            idx_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            sync_fval_q  <= 1'b0;
            sync_lval_q  <= 1'b0;
            frame_cnt_q  <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            rev_q        <= rev_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sync_fval_q  <= sync_fval_d;
            sync_lval_q  <= sync_lval_d;
            frame_cnt_q  <= frame_cnt_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
        end
    end

    assign o_pixel_valid = pix_valid_q;
    assign o_pixel_data  = pix_data_q;
    assign o_pixel_x     = pix_x_q;
    assign o_pixel_y     = pix_y_q;
    assign o_frame_done  = frame_done_q;
    assign o_line_err    = line_err_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_sync_fval   = sync_fval_q;
    assign o_sync_lval   = sync_lval_q;

endmodule
